// File: rtl/match_pkg.sv
// Shared types and constants for the N-player match controller.
// The LFSR constants are consumed only when MATCH_WIND_EN is defined.
package match_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_AIM     = 3'd1,
        ST_FLIGHT  = 3'd2,
        ST_RESOLVE = 3'd3,
        ST_OVER    = 3'd4
    } match_state_t;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS     = 16'hB400;
    localparam logic [5:0]  LFSR_SEED_PAD = 6'b101101;

    localparam logic signed [4:0] WIND_MIN = -5'sd15;
    localparam logic signed [4:0] WIND_MAX = 5'sd15;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], ^(v & LFSR_TAPS)};
    endfunction

    // A 5-bit signed value can never exceed WIND_MAX, so only the low end needs clamping
    function automatic logic signed [4:0] wind_clamp(input logic [4:0] raw);
        logic signed [4:0] w;
        w = signed'(raw);
        if (w < WIND_MIN) return WIND_MIN;
        return w;
    endfunction

endpackage

// File: rtl/match_ctrl_frame_tick_sync.sv
// Brings the VGA vertical-sync level into the clk domain and emits a
// one-cycle tick on each synchronised rising edge (3 clk cycles after the pin).
module frame_tick_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic frame_clk,
    output logic tick
);

    logic sync_1;
    logic sync_2;
    logic sync_3;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            sync_3 <= 1'b0;
            tick   <= 1'b0;
        end else begin
            sync_1 <= frame_clk;
            sync_2 <= sync_1;
            sync_3 <= sync_2;
            tick   <= sync_2 & ~sync_3;
        end
    end

endmodule

// File: rtl/match_ctrl.sv
// N-player turn/match controller: HP, turn arbitration, frame timers, win/draw.
// Optional per-turn wind LFSR enabled by defining MATCH_WIND_EN.
module match_ctrl
    import match_pkg::*;
#(
    parameter int unsigned NUM_PLAYERS   = 2,
    parameter int unsigned HP_W          = 10,
    parameter int unsigned HP_MAX        = 100,
    parameter int unsigned DMG_W         = 8,
    parameter int unsigned TURN_FRAMES   = 600,
    parameter int unsigned FLIGHT_FRAMES = 300
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           frame_clk,
    input  logic                           start,
    input  logic [9:0]                     rng_seed,
    input  logic [NUM_PLAYERS-1:0]         fire,
    input  logic [NUM_PLAYERS-1:0]         boomed,
    input  logic                           hit_valid,
    input  logic [$clog2(NUM_PLAYERS)-1:0] hit_player,
    input  logic [DMG_W-1:0]               hit_dmg,
    output logic [2:0]                     state,
    output logic [$clog2(NUM_PLAYERS)-1:0] active_player,
    output logic [NUM_PLAYERS-1:0]         fire_en,
    output logic [NUM_PLAYERS*HP_W-1:0]    hp,
    output logic [15:0]                    frames_left,
    output logic [$clog2(NUM_PLAYERS)-1:0] winner,
    output logic                           winner_valid,
    output logic                           draw,
    output logic signed [4:0]              wind
);

    localparam int unsigned     PW          = $clog2(NUM_PLAYERS);
    localparam logic [HP_W-1:0] HP_INIT     = HP_W'(HP_MAX);
    localparam logic [15:0]     TURN_INIT   = 16'(TURN_FRAMES);
    localparam logic [15:0]     FLIGHT_INIT = 16'(FLIGHT_FRAMES);

    match_state_t          state_q, state_nx;
    logic [PW-1:0]         active_q;
    logic [HP_W-1:0]       hp_q  [NUM_PLAYERS];
    logic [HP_W-1:0]       hp_nx [NUM_PLAYERS];
    logic [15:0]           frames_q;
    logic [PW-1:0]         winner_q;
    logic                  winner_valid_q;
    logic                  draw_q;
    logic                  tick;
    logic                  start_ok;
    logic                  hit_ok;
    logic                  fire_act;
    logic                  boom_act;
    logic                  expire;
    logic [NUM_PLAYERS-1:0] alive;
    logic [3:0]            alive_cnt;
    logic [PW-1:0]         last_alive;
    logic                  next_turn;

    frame_tick_sync u_tick (
        .clk       (clk),
        .reset_n   (reset_n),
        .frame_clk (frame_clk),
        .tick      (tick)
    );

    function automatic logic [PW-1:0] next_alive(input logic [NUM_PLAYERS-1:0] alive_v,
                                                 input logic [PW-1:0] cur);
        logic [PW-1:0] pick;
        logic          found;
        int unsigned   idx;
        pick  = cur;
        found = 1'b0;
        for (int unsigned k = 1; k < NUM_PLAYERS; k++) begin
            idx = (32'(cur) + k) % NUM_PLAYERS;
            if (!found && alive_v[idx]) begin
                pick  = PW'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign start_ok = start && (state_q == ST_IDLE || state_q == ST_OVER);
    assign hit_ok   = hit_valid && (state_q == ST_AIM || state_q == ST_FLIGHT || state_q == ST_RESOLVE);
    assign fire_act = fire[active_q];
    assign boom_act = boomed[active_q];
    assign expire   = tick && (frames_q <= 16'd1);

    // Out-of-range hit_player never matches a loop index, so it is dropped naturally
    always_comb begin
        for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
            hp_nx[p] = hp_q[p];
            if (start_ok) begin
                hp_nx[p] = HP_INIT;
            end else if (hit_ok && 32'(hit_player) == p) begin
                if (32'(hit_dmg) >= 32'(hp_q[p])) hp_nx[p] = '0;
                else                              hp_nx[p] = hp_q[p] - HP_W'(hit_dmg);
            end
        end
    end

    always_comb begin
        alive      = '0;
        alive_cnt  = '0;
        last_alive = '0;
        for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
            if (hp_nx[p] != '0) begin
                alive[p]   = 1'b1;
                alive_cnt  = alive_cnt + 4'd1;
                last_alive = PW'(p);
            end
        end
    end

    assign next_turn = (state_q == ST_RESOLVE) && (alive_cnt >= 4'd2);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_nx;
    end

    always_comb begin
        state_nx = state_q;
        unique case (state_q)
            ST_IDLE, ST_OVER: if (start) state_nx = ST_AIM;
            ST_AIM: begin
                if (fire_act)    state_nx = ST_FLIGHT;
                else if (expire) state_nx = ST_RESOLVE;
            end
            ST_FLIGHT:  if (boom_act || expire) state_nx = ST_RESOLVE;
            ST_RESOLVE: state_nx = (alive_cnt >= 4'd2) ? ST_AIM : ST_OVER;
            default:    state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        state   = state_q;
        fire_en = '0;
        if (state_q == ST_AIM) fire_en[active_q] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active_q       <= '0;
            frames_q       <= '0;
            winner_q       <= '0;
            winner_valid_q <= 1'b0;
            draw_q         <= 1'b0;
            for (int unsigned p = 0; p < NUM_PLAYERS; p++) hp_q[p] <= HP_INIT;
        end else begin
            for (int unsigned p = 0; p < NUM_PLAYERS; p++) hp_q[p] <= hp_nx[p];
            if (start_ok) begin
                active_q       <= '0;
                frames_q       <= TURN_INIT;
                winner_valid_q <= 1'b0;
                draw_q         <= 1'b0;
            end else begin
                unique case (state_q)
                    ST_AIM: begin
                        if (fire_act)                         frames_q <= FLIGHT_INIT;
                        else if (tick && frames_q != 16'd0)   frames_q <= frames_q - 16'd1;
                    end
                    ST_FLIGHT: if (tick && frames_q != 16'd0) frames_q <= frames_q - 16'd1;
                    ST_RESOLVE: begin
                        if (next_turn) begin
                            active_q <= next_alive(alive, active_q);
                            frames_q <= TURN_INIT;
                        end else if (alive_cnt == 4'd1) begin
                            winner_q       <= last_alive;
                            winner_valid_q <= 1'b1;
                        end else begin
                            draw_q <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        hp = '0;
        for (int unsigned p = 0; p < NUM_PLAYERS; p++) hp[p*HP_W +: HP_W] = hp_q[p];
    end

    assign active_player = active_q;
    assign frames_left   = frames_q;
    assign winner        = winner_q;
    assign winner_valid  = winner_valid_q;
    assign draw          = draw_q;

`ifdef MATCH_WIND_EN
    logic [15:0] lfsr_q;
    logic [15:0] seed_word;

    assign seed_word = (rng_seed == 10'd0) ? 16'h0001 : {LFSR_SEED_PAD, rng_seed};

    // Entering AIM from start steps the freshly loaded seed, so every turn sees a stepped value
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)       lfsr_q <= '0;
        else if (start_ok)  lfsr_q <= lfsr_step(seed_word);
        else if (next_turn) lfsr_q <= lfsr_step(lfsr_q);
    end

    assign wind = wind_clamp(lfsr_q[4:0]);
`else
    logic unused_seed;
    assign unused_seed = ^rng_seed;
    assign wind        = '0;
`endif

endmodule
